// File: rtl/ipml_prefetch_fifo_v2_0.sv
// ipml_prefetch_fifo_v2_0
// First-word-fall-through FIFO: simple-dual-port RAM with registered read,
// optional RAM output register, and a small skid buffer that keeps the head
// word presented ahead of rd_en and sustains one pop per clock.
module ipml_prefetch_fifo_v2_0 #(
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_DEPTH_WIDTH = 10,
    parameter int c_RAM_OUT_REG = 0,
    parameter int c_AF_LEVEL    = (1 << c_DEPTH_WIDTH) - 4,
    parameter int c_AE_LEVEL    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [c_DATA_WIDTH-1:0]    wr_data,
    input  logic                       wr_en,
    output logic                       wr_vld,
    output logic [c_DATA_WIDTH-1:0]    rd_data,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic [c_DEPTH_WIDTH+1:0]   level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DEPTH = 1 << c_DEPTH_WIDTH;
    localparam int SKID  = 2 + c_RAM_OUT_REG;
    localparam int CW    = c_DEPTH_WIDTH + 1;   // RAM count width
    localparam int LW    = c_DEPTH_WIDTH + 2;   // total level width

    localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
    localparam logic [CW-1:0] AF_L    = CW'(c_AF_LEVEL);
    localparam logic [LW-1:0] AE_L    = LW'(c_AE_LEVEL);
    localparam logic [1:0]    SKID_L  = 2'(SKID);

    // RAM storage and its registered read port
    logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
    logic [c_DATA_WIDTH-1:0]  ram_dout_q;
    logic                     ram_dout_vld_q;

    // Skid buffer: indexed by a 2-bit pointer, only SKID slots are used
    logic [c_DATA_WIDTH-1:0]  skid_mem [4];
    logic [1:0]               skid_wr_q, skid_rd_q;
    logic [1:0]               skid_cnt_q, skid_cnt_d;

    // Pointers and counters
    logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            ram_cnt_q, ram_cnt_d;   // words in RAM not yet issued
    logic [1:0]               pipe_cnt_q, pipe_cnt_d; // in-flight reads + skid entries
    logic [LW-1:0]            level_q, level_d;

    // Registered outputs
    logic wr_vld_q, rd_vld_q, af_q, ae_q, ovf_q, unf_q;

    // Word arriving at the skid buffer from the read pipeline
    logic [c_DATA_WIDTH-1:0]  land_data;
    logic                     land_vld;

    logic wr_acc, pop, issue;

    function automatic logic [1:0] skid_next(input logic [1:0] idx);
        return (idx == SKID_L - 2'd1) ? 2'd0 : idx + 2'd1;
    endfunction

    // Handshakes, prefetch decision and next-state counts
    always_comb begin
        // NOTE: every variable gets a value on every path here, so no latches are inferred.
        wr_acc     = wr_en & wr_vld_q & ~flush;
        pop        = rd_en & rd_vld_q & ~flush;
        issue      = ~flush & (ram_cnt_q != '0) & ((pipe_cnt_q < SKID_L) | pop);
        ram_cnt_d  = ram_cnt_q + CW'(wr_acc) - CW'(issue);
        pipe_cnt_d = pipe_cnt_q + 2'(issue) - 2'(pop);
        skid_cnt_d = skid_cnt_q + 2'(land_vld) - 2'(pop);
        level_d    = level_q + LW'(wr_acc) - LW'(pop);
        if (flush) begin
            ram_cnt_d  = '0;
            pipe_cnt_d = '0;
            skid_cnt_d = '0;
            level_d    = '0;
        end
    end

    // RAM write port and registered read port
    always_ff @(posedge clk) begin
        // NOTE: storage arrays carry no reset; validity is tracked by the counters and valid bits.
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
        if (issue)  ram_dout_q    <= mem[rd_ptr_q];
    end

    generate
        if (c_RAM_OUT_REG != 0) begin : g_out_reg
            logic [c_DATA_WIDTH-1:0] out_data_q;
            logic                    out_vld_q;

            // Optional RAM output register, data path
            always_ff @(posedge clk) begin
                out_data_q <= ram_dout_q;
            end

            // Optional RAM output register, valid bit (dropped by flush)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) out_vld_q <= 1'b0;
                else        out_vld_q <= ram_dout_vld_q & ~flush;
            end

            assign land_data = out_data_q;
            assign land_vld  = out_vld_q;
        end else begin : g_no_out_reg
            assign land_data = ram_dout_q;
            assign land_vld  = ram_dout_vld_q;
        end
    endgenerate

    // Skid buffer storage, written as read data lands
    always_ff @(posedge clk) begin
        if (land_vld & ~flush) skid_mem[skid_wr_q] <= land_data;
    end

    // Pointers, counters, registered status and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            skid_wr_q      <= '0;
            skid_rd_q      <= '0;
            ram_cnt_q      <= '0;
            pipe_cnt_q     <= '0;
            skid_cnt_q     <= '0;
            level_q        <= '0;
            ram_dout_vld_q <= 1'b0;
            wr_vld_q       <= 1'b1;
            rd_vld_q       <= 1'b0;
            af_q           <= 1'b0;
            ae_q           <= 1'b1;
            ovf_q          <= 1'b0;
            unf_q          <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                skid_wr_q <= '0;
                skid_rd_q <= '0;
            end else begin
                if (wr_acc)   wr_ptr_q  <= wr_ptr_q + c_DEPTH_WIDTH'(1);
                if (issue)    rd_ptr_q  <= rd_ptr_q + c_DEPTH_WIDTH'(1);
                if (land_vld) skid_wr_q <= skid_next(skid_wr_q);
                if (pop)      skid_rd_q <= skid_next(skid_rd_q);
            end
            ram_cnt_q      <= ram_cnt_d;
            pipe_cnt_q     <= pipe_cnt_d;
            skid_cnt_q     <= skid_cnt_d;
            level_q        <= level_d;
            ram_dout_vld_q <= issue;
            wr_vld_q       <= (ram_cnt_d < DEPTH_L);
            rd_vld_q       <= (skid_cnt_d != '0);
            af_q           <= (ram_cnt_d >= AF_L);
            ae_q           <= (level_d <= AE_L);
            ovf_q          <= ~flush & (ovf_q | (wr_en & ~wr_vld_q));
            unf_q          <= ~flush & (unf_q | (rd_en & ~rd_vld_q));
        end
    end

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = rd_vld_q ? skid_mem[skid_rd_q] : '0;
    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: doc/ipml_prefetch_fifo_v2_0.md
Name: ipml_prefetch_fifo_v2_0

Overview:
- Single-clock, first-word-fall-through (prefetch) FIFO with ready/valid on both sides.
- Storage is an inferred simple-dual-port RAM with registered read, followed by an internal skid buffer.
- The skid buffer keeps rd_data valid ahead of rd_en and sustains one pop per clock.
- Successor to the current prefetch FIFO. Adds:
  - an optional RAM output register;
  - programmable almost-full and almost-empty thresholds;
  - an occupancy level output;
  - synchronous flush;
  - sticky overflow and underflow flags.
- Used between pixel/feature-map producers and the conv pipeline.

Parameters:
- c_DATA_WIDTH, 32, data width in bits (1..1152).
- c_DEPTH_WIDTH, 10, RAM address width. RAM holds 2^c_DEPTH_WIDTH words (legal 4..16).
- c_RAM_OUT_REG, 0, 1 adds a RAM output register: +1 cycle latency, +1 skid entry.
- c_AF_LEVEL, 2^c_DEPTH_WIDTH-4, almost_full asserts when ram_count >= c_AF_LEVEL.
- c_AE_LEVEL, 2, almost_empty asserts when level <= c_AE_LEVEL.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear, single-cycle pulse or level.
- wr_data  in  c_DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_vld  out  1  write ready; a write is accepted when wr_en & wr_vld.
- rd_data  out  c_DATA_WIDTH  head-of-queue data, valid when rd_vld=1.
- rd_en  in  1  pop request; a pop occurs when rd_en & rd_vld.
- rd_vld  out  1  head data valid.
- level  out  c_DEPTH_WIDTH+2  words accepted minus words popped.
- almost_full  out  1  RAM occupancy at or above threshold.
- almost_empty  out  1  total occupancy at or below threshold.
- overflow  out  1  sticky: write attempted while wr_vld=0.
- underflow  out  1  sticky: rd_en while rd_vld=0.

Behaviour:
- Reset: rst_n is asynchronous and active-low; all state returns to its reset value while rst_n=0.
- Reset values of outputs:
  - rd_vld=0, wr_vld=1, level=0, almost_full=0, almost_empty=1, overflow=0, underflow=0;
  - rd_data=0, and rd_data also reads 0 whenever rd_vld=0.
- Capacity:
  - SKID = 2 + c_RAM_OUT_REG;
  - total capacity = 2^c_DEPTH_WIDTH + SKID words.
- ram_count: words in RAM that have not yet been issued to a read. wr_vld = (ram_count < 2^c_DEPTH_WIDTH).
- Prefetch: a RAM read is issued in any cycle where ram_count > 0 and (skid occupancy + reads in flight) < SKID, or where a pop frees a slot in the same cycle.
- Latency: a word accepted at edge E into an empty FIFO shows rd_vld=1 and rd_data=word after edge E+2+c_RAM_OUT_REG.
- Throughput: with rd_en held high and a continuous write stream, one word per clock is popped with no bubbles after the initial latency.
- Ordering: strict FIFO order. Data is never duplicated or lost except by flush.
- Simultaneous write and pop: level is unchanged. Simultaneous write and pop at full: the write is refused (wr_vld was 0 that cycle), and wr_vld rises on the next cycle.
- Pointer wrap-around is modulo 2^c_DEPTH_WIDTH, with no gap at wrap.
- level:
  - +1 per accepted write, -1 per pop;
  - registered, updated at the same edge as the event;
  - never exceeds total capacity and never goes below 0.
- Flags:
  - almost_full and almost_empty are registered from next-state counts; no combinational paths from inputs to outputs except none.
  - rd_vld and wr_vld are registered.
- overflow is set at the edge after wr_en=1 & wr_vld=0. underflow is set at the edge after rd_en=1 & rd_vld=0.
- Both sticky flags clear only on reset or flush. Refused writes and refused pops have no other effect.
- Flush (sampled at an edge):
  - all pointers, counts, skid contents, in-flight reads and sticky flags clear at that edge;
  - next cycle: rd_vld=0, wr_vld=1, level=0;
  - writes and pops presented in the flush cycle are discarded and do not count;
  - flush overrides all other events.

Test Plan:
- c_DEPTH_WIDTH=4, c_RAM_OUT_REG=0. Single write 0xA5 at edge E, rd_en=0 -> rd_vld=1 and rd_data=0xA5 after E+2; level=1; almost_empty=1.
- Same config. Write 0..19 with rd_en=0 -> exactly 18 accepted (0..17); wr_vld=0 after the 18th; overflow=1 after the first refused write; level=18. Then pop all -> 0..17 in order, and rd_vld=0 after the last pop.
- c_RAM_OUT_REG=1. Continuous write 0..99 with rd_en=1 throughout -> first pop 3 edges after the first write, then 100 consecutive pops with no bubbles; level never exceeds 4.
- Fill to 10 words, then pulse flush together with wr_en=1 and rd_en=1 -> next cycle level=0, rd_vld=0, wr_vld=1, overflow=0, underflow=0. A subsequent write 0x1 is read back as the sole word.
- Empty FIFO, rd_en=1 for 1 cycle -> underflow=1 with no other state change. Assert rst_n=0 mid-stream -> all outputs take their reset values immediately (asynchronously).
- c_AF_LEVEL=12, c_AE_LEVEL=2. Random write/read traffic for 10k cycles -> scoreboard matches order; almost_full tracks ram_count>=12; almost_empty tracks level<=2; wrap-around is exercised at least 100 times.
